// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
//   Shared definitions for the branch predictor slice: 2-bit counter state
//   encoding, BTB field widths and the saturating perf-counter helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  localparam int PC_W  = 32;         // fetch / resolve address width
  localparam int TGT_W = PC_W - 2;   // stored target, word aligned
  localparam int CTR_W = 2;          // direction counter width

  // Direction counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  typedef enum logic [CTR_W-1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } ctr_e;

  localparam logic [PC_W-1:0] PERF_MAX = 32'hFFFF_FFFF;

  // Perf counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [PC_W-1:0] sat_inc32(input logic [PC_W-1:0] v,
                                                input logic            en);
    logic [PC_W-1:0] r;
    if (en && (v != PERF_MAX)) begin
      r = v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//   Bundles the fetch lookup port and the execute resolution port.
//   master : fetch/execute side (drives if_pc and upd_*, reads prediction)
//   slave  : predictor side (reads if_pc and upd_*, drives hit/taken/pred_PC)
// -----------------------------------------------------------------------------
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  // Fetch lookup
  logic [PC_W-1:0] if_pc;
  logic            hit;
  logic            taken;
  logic [PC_W-1:0] pred_PC;

  // Execute resolution
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_is_jump;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_mispred;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_mispred,
    input  hit, taken, pred_PC
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_mispred,
    output hit, taken, pred_PC
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// branch_predictor_sat_counter
//   Combinational next state of a 2-bit saturating direction counter.
//   cur : present counter state
//   inc : 1 = branch taken (step toward strong-T), 0 = step toward strong-NT
//   nxt : next counter state, clamped at BP_SNT / BP_ST
// -----------------------------------------------------------------------------
module branch_predictor_sat_counter
  import branch_predictor_pkg::*;
(
  input  ctr_e cur,
  input  logic inc,
  output ctr_e nxt
);

  // One saturating step in the direction of the resolved outcome.
  always_comb begin
    nxt = cur;
    case (cur)
      BP_SNT:  nxt = inc ? BP_WNT : BP_SNT;
      BP_WNT:  nxt = inc ? BP_WT  : BP_SNT;
      BP_WT:   nxt = inc ? BP_ST  : BP_WNT;
      BP_ST:   nxt = inc ? BP_ST  : BP_WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with a 2-bit direction counter per entry. Lookup is
//   combinational on the fetch PC; the table is written on the clock edge
//   after an execute resolution, so a same-cycle lookup sees the old entry.
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active-low
//   bp          : branch_predictor_if.slave (lookup + resolution)
//   cnt_lookup  : number of cycles with hit=1 since reset (saturating)
//   cnt_mispred : number of upd_valid & upd_mispred events (saturating)
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_predictor_if.slave      bp,
  output logic [PC_W-1:0]        cnt_lookup,
  output logic [PC_W-1:0]        cnt_mispred
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = PC_W - IDXW - 2;

  // Entry state that must clear on reset
  logic [ENTRIES-1:0]            valid_r;
  logic [ENTRIES-1:0]            is_jump_r;
  logic [ENTRIES-1:0][CTR_W-1:0] ctr_r;
  // Payload storage; only meaningful behind a set valid bit
  logic [TAGW-1:0]               tag_r [ENTRIES];
  logic [TGT_W-1:0]              tgt_r [ENTRIES];

  logic [PC_W-1:0]               cnt_lookup_r;
  logic [PC_W-1:0]               cnt_mispred_r;

  // Lookup side
  logic [IDXW-1:0]               lk_idx_s;
  logic [TAGW-1:0]               lk_tag_s;
  logic                          hit_s;
  logic                          taken_s;
  logic [PC_W-1:0]               pred_s;

  // Update side
  logic                          upd_en_s;
  logic [IDXW-1:0]               up_idx_s;
  logic [TAGW-1:0]               up_tag_s;
  logic                          up_hit_s;
  ctr_e                          ctr_cur_s;
  ctr_e                          ctr_step_s;
  ctr_e                          new_ctr_s;
  logic                          new_jump_s;
  logic                          wr_meta_s;
  logic                          wr_tgt_s;

  // Byte-offset bits never take part in indexing or tagging
  logic                          unused_bits_s;
  assign unused_bits_s = ^{bp.if_pc[1:0], bp.upd_pc[1:0], bp.upd_target[1:0]};

  assign lk_idx_s = bp.if_pc[IDXW+1:2];
  assign lk_tag_s = bp.if_pc[PC_W-1:IDXW+2];
  assign up_idx_s = bp.upd_pc[IDXW+1:2];
  assign up_tag_s = bp.upd_pc[PC_W-1:IDXW+2];

  // Resolutions arriving while reset is held are dropped.
  assign upd_en_s  = bp.upd_valid & rst;
  assign ctr_cur_s = ctr_e'(ctr_r[up_idx_s]);

  // Zero-latency prediction from the current (pre-update) table contents.
  always_comb begin
    hit_s   = 1'b0;
    taken_s = 1'b0;
    pred_s  = 32'd0;
    if (rst && valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
      hit_s   = 1'b1;
      taken_s = is_jump_r[lk_idx_s] | ctr_r[lk_idx_s][1];
      pred_s  = {tgt_r[lk_idx_s], 2'b00};
    end else begin
      hit_s   = 1'b0;
      taken_s = 1'b0;
      pred_s  = 32'd0;
    end
  end

  assign bp.hit     = hit_s;
  assign bp.taken   = taken_s;
  assign bp.pred_PC = pred_s;

  assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

  branch_predictor_sat_counter u_sat_counter (
    .cur (ctr_cur_s),
    .inc (bp.upd_taken),
    .nxt (ctr_step_s)
  );

  // Decide what a resolution writes: train on hit, allocate on taken miss.
  always_comb begin
    wr_meta_s  = 1'b0;
    wr_tgt_s   = 1'b0;
    new_ctr_s  = ctr_cur_s;
    new_jump_s = is_jump_r[up_idx_s];
    if (upd_en_s) begin
      if (up_hit_s) begin
        wr_meta_s  = 1'b1;
        new_jump_s = bp.upd_is_jump;
        if (bp.upd_is_jump) begin
          new_ctr_s = BP_ST;
          wr_tgt_s  = 1'b1;
        end else begin
          new_ctr_s = ctr_step_s;
          // A not-taken branch carries no useful target
          wr_tgt_s  = bp.upd_taken;
        end
      end else if (bp.upd_taken) begin
        wr_meta_s  = 1'b1;
        wr_tgt_s   = 1'b1;
        new_jump_s = bp.upd_is_jump;
        new_ctr_s  = bp.upd_is_jump ? BP_ST : ctr_e'(CNT_INIT);
      end else begin
        wr_meta_s = 1'b0;
        wr_tgt_s  = 1'b0;
      end
    end else begin
      wr_meta_s = 1'b0;
      wr_tgt_s  = 1'b0;
    end
  end

  // Valid / kind / counter state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r   <= {ENTRIES{1'b0}};
      is_jump_r <= {ENTRIES{1'b0}};
      ctr_r     <= {ENTRIES{2'b00}};
    end else if (wr_meta_s) begin
      valid_r[up_idx_s]   <= 1'b1;
      is_jump_r[up_idx_s] <= new_jump_s;
      ctr_r[up_idx_s]     <= new_ctr_s;
    end
  end

  // Tag and target payload; written with the entry, never reset.
  always_ff @(posedge clk) begin
    if (wr_tgt_s) begin
      tag_r[up_idx_s] <= up_tag_s;
      tgt_r[up_idx_s] <= bp.upd_target[PC_W-1:2];
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lookup_r  <= 32'd0;
      cnt_mispred_r <= 32'd0;
    end else begin
      cnt_lookup_r  <= sat_inc32(cnt_lookup_r, hit_s);
      cnt_mispred_r <= sat_inc32(cnt_mispred_r, upd_en_s & bp.upd_mispred);
    end
  end

  assign cnt_lookup  = cnt_lookup_r;
  assign cnt_mispred = cnt_mispred_r;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Self-checking bench for branch_predictor (ENTRIES=16, CNT_INIT=2'b10).
//   Each table row is one clock cycle: lookup address and resolution are
//   driven together, the expected (pre-update) prediction is queued, and the
//   queue is popped and compared mid-cycle.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] cnt_lookup;
  logic [31:0] cnt_mispred;

  branch_predictor_if bus ();

  branch_predictor #(
    .ENTRIES  (16),
    .CNT_INIT (2'b10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bp          (bus),
    .cnt_lookup  (cnt_lookup),
    .cnt_mispred (cnt_mispred)
  );

  typedef struct {
    logic [31:0] lk;
    logic        uv;
    logic [31:0] upc;
    logic        uj;
    logic        ut;
    logic [31:0] utg;
    logic        um;
    logic        eh;
    logic        et;
    logic [31:0] ep;
  } vec_t;

  typedef struct {
    logic        h;
    logic        t;
    logic [31:0] p;
    int          id;
  } exp_t;

  vec_t vt [16];
  exp_t sbq [$];

  int n_vec;
  int n_bad;
  int exp_lookups;
  int exp_misp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.if_pc       = v.lk;
    bus.upd_valid   = v.uv;
    bus.upd_pc      = v.upc;
    bus.upd_is_jump = v.uj;
    bus.upd_taken   = v.ut;
    bus.upd_target  = v.utg;
    bus.upd_mispred = v.um;
  endtask

  // One cycle: drive after the edge, check the prediction mid-cycle.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    sbq.push_back('{v.eh, v.et, v.ep, id});
    @(negedge clk);
    if (sbq.size() == 0) begin
      cmp("sb_empty", id, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      cmp("hit",     e.id, {31'd0, bus.hit},   {31'd0, e.h});
      cmp("taken",   e.id, {31'd0, bus.taken}, {31'd0, e.t});
      cmp("pred_PC", e.id, bus.pred_PC,        e.p);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                              input logic uj, input logic ut, input logic [31:0] utg,
                              input logic um, input logic eh, input logic et,
                              input logic [31:0] ep);
    vec_t v;
    v.lk = lk;  v.uv = uv;  v.upc = upc; v.uj = uj; v.ut = ut;
    v.utg = utg; v.um = um; v.eh = eh;   v.et = et; v.ep = ep;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    exp_lookups = 0;
    exp_misp = 0;

    // idx = pc[5:2]; 0x100, 0x140, 0x200 and 0x300 all share idx 0
    //               lk        uv    upc       uj    ut    utg       um    eh    et    ep
    vt[0]  = mk(32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    vt[1]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h180, 1'b1, 1'b0, 1'b0, 32'h000); // alloc ctr=10
    vt[2]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h180); // 10->01
    vt[3]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h180); // 01->00
    vt[4]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 32'h180); // 00 stays
    vt[5]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h180, 1'b0, 1'b1, 1'b0, 32'h180); // 00->01
    vt[6]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h180, 1'b0, 1'b1, 1'b0, 32'h180); // 01->10
    vt[7]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h1C0, 1'b0, 1'b1, 1'b1, 32'h180); // 10->11, new tgt
    vt[8]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h1C0, 1'b0, 1'b1, 1'b1, 32'h1C0); // 11 stays
    vt[9]  = mk(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h1C0); // 11->10, tgt kept
    vt[10] = mk(32'h100, 1'b1, 32'h140, 1'b1, 1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 32'h1C0); // jump evicts
    vt[11] = mk(32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000); // mispred w/o valid
    vt[12] = mk(32'h140, 1'b1, 32'h200, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h400); // NT miss: no change
    vt[13] = mk(32'h140, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h400);
    vt[14] = mk(32'h200, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    vt[15] = mk(32'h143, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h400); // pc[1:0] ignored

    // Reset state
    rst = 1'b0;
    drive(mk(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    #3;
    cmp("rst_hit",     0, {31'd0, bus.hit},   32'd0);
    cmp("rst_taken",   0, {31'd0, bus.taken}, 32'd0);
    cmp("rst_pred",    0, bus.pred_PC,        32'd0);
    cmp("rst_lookups", 0, cnt_lookup,         32'd0);
    cmp("rst_misp",    0, cnt_mispred,        32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven main sequence
    for (int i = 0; i < 16; i++) begin
      apply(vt[i], i);
      exp_lookups += int'(vt[i].eh);
      exp_misp    += int'(vt[i].uv & vt[i].um);
    end
    @(posedge clk);
    #1;
    drive(mk(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    cmp("cnt_lookup",  100, cnt_lookup,  exp_lookups);
    cmp("cnt_mispred", 100, cnt_mispred, exp_misp);

    // Same-cycle lookup and update on idx 0: old target now, new target next cycle
    apply(mk(32'h140, 1'b1, 32'h140, 1'b1, 1'b1, 32'h800, 1'b0, 1'b1, 1'b1, 32'h400), 200);
    apply(mk(32'h140, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h800), 201);

    // Reset mid-stream with an update pending
    @(posedge clk);
    #1;
    drive(mk(32'h140, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0));
    #2;
    cmp("pre_rst_hit", 300, {31'd0, bus.hit}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    cmp("mid_rst_hit",   301, {31'd0, bus.hit},   32'd0);
    cmp("mid_rst_taken", 301, {31'd0, bus.taken}, 32'd0);
    cmp("mid_rst_pred",  301, bus.pred_PC,        32'd0);
    cmp("mid_rst_look",  301, cnt_lookup,         32'd0);
    cmp("mid_rst_misp",  301, cnt_mispred,        32'd0);
    @(posedge clk);
    #1;
    cmp("in_rst_misp",   302, cnt_mispred,        32'd0);
    @(negedge clk);
    rst = 1'b1;
    // First post-reset update rides the first posedge after release (mispred pulse 1)
    drive(mk(32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0));
    #1;
    cmp("post_rst_300", 303, {31'd0, bus.hit}, 32'd0);
    bus.if_pc = 32'h140;
    #1;
    cmp("post_rst_140", 304, {31'd0, bus.hit}, 32'd0);
    bus.if_pc = 32'h300;
    @(posedge clk);
    #1;
    // Mispred pulse 2 on a not-taken miss (no table change)
    drive(mk(32'h300, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
    #1;
    cmp("first_upd_hit",   305, {31'd0, bus.hit},   32'd1);
    cmp("first_upd_taken", 305, {31'd0, bus.taken}, 32'd1);
    cmp("first_upd_pred",  305, bus.pred_PC,        32'h500);
    @(posedge clk);
    #1;
    drive(mk(32'h0, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    // Mispred pulse 3
    drive(mk(32'h0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    drive(mk(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    cmp("misp_pulses", 306, cnt_mispred, 32'd3);
    cmp("look_post",   306, cnt_lookup,  32'd1);

    if (sbq.size() != 0) begin
      cmp("sb_leftover", 400, sbq.size(), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
